// File: rtl/inert_sensor_serf_pkg.sv
// Shared definitions for the inertial-sensor SPI responder: frame geometry,
// register addresses, reset values and the frame-tracking state type.
package inert_sensor_serf_pkg;

   localparam int FRAME_W = 16;
   localparam int ADDR_W  = 7;
   localparam int CNT_W   = 5;

   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_W);
   localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(FRAME_W / 2);

   localparam logic [ADDR_W-1:0] ADDR_INT_CTRL = 7'h0D;
   localparam logic [ADDR_W-1:0] ADDR_WHO_AM_I = 7'h0F;
   localparam logic [ADDR_W-1:0] ADDR_CTRL1_XL = 7'h10;
   localparam logic [ADDR_W-1:0] ADDR_CTRL2_G  = 7'h11;
   localparam logic [ADDR_W-1:0] ADDR_CTRL_RND = 7'h14;
   localparam logic [ADDR_W-1:0] ADDR_ROLL_L   = 7'h24;
   localparam logic [ADDR_W-1:0] ADDR_ROLL_H   = 7'h25;
   localparam logic [ADDR_W-1:0] ADDR_YAW_L    = 7'h26;
   localparam logic [ADDR_W-1:0] ADDR_YAW_H    = 7'h27;
   localparam logic [ADDR_W-1:0] ADDR_AY_L     = 7'h2A;
   localparam logic [ADDR_W-1:0] ADDR_AY_H     = 7'h2B;
   localparam logic [ADDR_W-1:0] ADDR_AZ_L     = 7'h2C;
   localparam logic [ADDR_W-1:0] ADDR_AZ_H     = 7'h2D;

   localparam logic [7:0]  REG_RST  = 8'h00;
   localparam logic [15:0] SMPL_RST = 16'h0000;

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} serf_state_t;

   // One full inertial sample as delivered by the front end
   typedef struct packed {
      logic [15:0] roll;
      logic [15:0] yaw;
      logic [15:0] ay;
      logic [15:0] az;
   } sample_t;

   // True for the configuration registers the master may write
   function automatic logic is_rw_addr(input logic [ADDR_W-1:0] a);
      return (a == ADDR_INT_CTRL) || (a == ADDR_CTRL1_XL) ||
             (a == ADDR_CTRL2_G)  || (a == ADDR_CTRL_RND);
   endfunction

endpackage

// File: rtl/inert_sensor_serf_if.sv
// SPI wire bundle between the eBike master and the sensor responder.
interface inert_sensor_serf_if;

   logic SS_n;
   logic SCLK;
   logic MOSI;
   logic MISO;

   modport master (output SS_n, output SCLK, output MOSI, input MISO);
   modport slave  (input SS_n, input SCLK, input MOSI, output MISO);

endinterface

// File: rtl/inert_sensor_serf_shft.sv
// SPI framing engine: brings the master's wires into the clk domain, tracks the
// frame, assembles the 16-bit command and serialises read data back on MISO.
module inert_sensor_serf_shft
   import inert_sensor_serf_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   inert_sensor_serf_if.slave spi,
   input  logic [7:0]        rd_data,
   output logic [ADDR_W-1:0] addr,
   output logic [7:0]        wdata,
   output logic              rd_req,
   output logic              wr_commit,
   output logic              rd_commit,
   output logic              ss_low
);

   logic [2:0]         ss_sync;
   logic [2:0]         sclk_sync;
   logic [1:0]         mosi_sync;
   logic               ss_fall, ss_rise, sclk_rise, sclk_fall, mosi_bit;
   serf_state_t        state, next_state;
   logic               shifting, frame_end, full;
   logic [CNT_W-1:0]   bit_cnt;
   logic [FRAME_W-1:0] rx_shft;
   logic [7:0]         tx_shft;
   logic               tx_loaded;

   // Double-flop the asynchronous SPI wires; a third SS_n/SCLK stage feeds edge detection
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ss_sync   <= 3'b111;
         sclk_sync <= 3'b111;
         mosi_sync <= 2'b00;
      end else begin
         ss_sync   <= {ss_sync[1:0], spi.SS_n};
         sclk_sync <= {sclk_sync[1:0], spi.SCLK};
         mosi_sync <= {mosi_sync[0], spi.MOSI};
      end
   end

   assign ss_fall   =  ss_sync[2] & ~ss_sync[1];
   assign ss_rise   = ~ss_sync[2] &  ss_sync[1];
   assign sclk_rise = ~sclk_sync[2] &  sclk_sync[1];
   assign sclk_fall =  sclk_sync[2] & ~sclk_sync[1];
   assign mosi_bit  =  mosi_sync[1];
   assign ss_low    = ~ss_sync[1];

   // Frame state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= next_state;
   end

   // Frame opens on SS_n fall, closes on SS_n rise, then one cycle to act on it
   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (ss_fall) next_state = SHIFT;
         SHIFT:   if (ss_rise) next_state = DONE;
         DONE:    next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // Decode the frame state into shift enable and end-of-frame commit strobes
   always_comb begin
      shifting  = (state == SHIFT);
      frame_end = (state == DONE);
      full      = (bit_cnt == CNT_FULL);
      wr_commit = frame_end & full & ~rx_shft[FRAME_W-1];
      rd_commit = frame_end & full &  rx_shft[FRAME_W-1];
      rd_req    = shifting & sclk_fall & (bit_cnt == CNT_HALF) & ~tx_loaded & rx_shft[7];
   end

   // Receive shifter and bit counter; stops at a full frame so extra clocks are ignored
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bit_cnt <= '0;
         rx_shft <= '0;
      end else if (ss_fall) begin
         bit_cnt <= '0;
         rx_shft <= '0;
      end else if (shifting && sclk_rise && (bit_cnt != CNT_FULL)) begin
         rx_shft <= {rx_shft[FRAME_W-2:0], mosi_bit};
         bit_cnt <= bit_cnt + 1'b1;
      end
   end

   // Transmit shifter: loaded from the register map once the read address is known
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tx_shft   <= 8'h00;
         tx_loaded <= 1'b0;
      end else if (ss_fall || ss_rise) begin
         tx_shft   <= 8'h00;
         tx_loaded <= 1'b0;
      end else if (rd_req) begin
         tx_shft   <= rd_data;
         tx_loaded <= 1'b1;
      end else if (shifting && sclk_fall && tx_loaded) begin
         tx_shft   <= {tx_shft[6:0], 1'b0};
      end
   end

   // Address comes from the upper byte once the frame is complete, the first byte before that
   assign addr     = full ? rx_shft[14:8] : rx_shft[6:0];
   assign wdata    = rx_shft[7:0];
   assign spi.MISO = tx_loaded & tx_shft[7];

endmodule

// File: rtl/inert_sensor_serf.sv
// Inertial-sensor SPI responder: register map, sample capture with a pending
// buffer for samples that arrive mid-frame, data-ready interrupt and overrun flag.
module inert_sensor_serf
   import inert_sensor_serf_pkg::*;
#(
   parameter logic [7:0] WHOAMI  = 8'h6A,
   parameter int         INT_BIT = 1
)(
   input  logic              clk,
   input  logic              rst_n,
   inert_sensor_serf_if.slave spi,
   input  logic              smpl_vld,
   input  logic [15:0]       roll_rt,
   input  logic [15:0]       yaw_rt,
   input  logic [15:0]       AY,
   input  logic [15:0]       AZ,
   output logic              INT,
   output logic              ovr
);

   logic [ADDR_W-1:0] addr;
   logic [7:0]        wdata, rd_data;
   logic              rd_req, wr_commit, rd_commit, ss_low;
   logic [7:0]        int_ctrl, ctrl1_xl, ctrl2_g, ctrl_rnd;
   sample_t           smpl_in, data_q, pend_buf, load_src;
   logic              pend_vld, direct_load, pend_load, data_load, load_q;
   logic              int_en;

   inert_sensor_serf_shft u_shft (
      .clk       (clk),
      .rst_n     (rst_n),
      .spi       (spi),
      .rd_data   (rd_data),
      .addr      (addr),
      .wdata     (wdata),
      .rd_req    (rd_req),
      .wr_commit (wr_commit),
      .rd_commit (rd_commit),
      .ss_low    (ss_low)
   );

   assign smpl_in = {roll_rt, yaw_rt, AY, AZ};
   assign int_en  = int_ctrl[INT_BIT];

   // Samples go straight in while the bus is idle; a parked sample goes in once the frame ends
   always_comb begin
      direct_load = smpl_vld & ~ss_low;
      pend_load   = pend_vld & ~ss_low;
      data_load   = direct_load | pend_load;
      load_src    = direct_load ? smpl_in : pend_buf;
   end

   // Park samples that arrive during a frame so a read never sees a torn sample
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend_vld <= 1'b0;
         pend_buf <= {SMPL_RST, SMPL_RST, SMPL_RST, SMPL_RST};
      end else if (smpl_vld && ss_low) begin
         pend_vld <= 1'b1;
         pend_buf <= smpl_in;
      end else if (pend_load) begin
         pend_vld <= 1'b0;
      end
   end

   // Data registers and a one-cycle delayed load marker that drives the interrupt
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_q <= {SMPL_RST, SMPL_RST, SMPL_RST, SMPL_RST};
         load_q <= 1'b0;
      end else begin
         load_q <= data_load;
         if (data_load) data_q <= load_src;
      end
   end

   // Configuration registers, written only by a complete write frame
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         int_ctrl <= REG_RST;
         ctrl1_xl <= REG_RST;
         ctrl2_g  <= REG_RST;
         ctrl_rnd <= REG_RST;
      end else if (wr_commit && is_rw_addr(addr)) begin
         case (addr)
            ADDR_INT_CTRL: int_ctrl <= wdata;
            ADDR_CTRL1_XL: ctrl1_xl <= wdata;
            ADDR_CTRL2_G:  ctrl2_g  <= wdata;
            ADDR_CTRL_RND: ctrl_rnd <= wdata;
            default:       ;
         endcase
      end
   end

   // Read mux over the register map; unmapped addresses read as zero
   always_comb begin
      rd_data = 8'h00;
      case (addr)
         ADDR_INT_CTRL: rd_data = int_ctrl;
         ADDR_WHO_AM_I: rd_data = WHOAMI;
         ADDR_CTRL1_XL: rd_data = ctrl1_xl;
         ADDR_CTRL2_G:  rd_data = ctrl2_g;
         ADDR_CTRL_RND: rd_data = ctrl_rnd;
         ADDR_ROLL_L:   rd_data = data_q.roll[7:0];
         ADDR_ROLL_H:   rd_data = data_q.roll[15:8];
         ADDR_YAW_L:    rd_data = data_q.yaw[7:0];
         ADDR_YAW_H:    rd_data = data_q.yaw[15:8];
         ADDR_AY_L:     rd_data = data_q.ay[7:0];
         ADDR_AY_H:     rd_data = data_q.ay[15:8];
         ADDR_AZ_L:     rd_data = data_q.az[7:0];
         ADDR_AZ_H:     rd_data = data_q.az[15:8];
         default:       rd_data = 8'h00;
      endcase
   end

   // Interrupt: raised after a load when enabled, dropped by a complete AZ high-byte read
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                               INT <= 1'b0;
      else if (load_q && int_en)                INT <= 1'b1;
      else if (rd_commit && addr == ADDR_AZ_H)  INT <= 1'b0;
   end

   // Sticky overrun: a new sample overwrote data the master had not yet collected
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                ovr <= 1'b0;
      else if (data_load && INT) ovr <= 1'b1;
   end

endmodule

// File: tb/tb_inert_sensor_serf.sv
// Bench for the inertial-sensor SPI responder: a transaction-level model of the
// register map, interrupt and overrun behaviour, driven by randomized SPI frames.
module tb_inert_sensor_serf;

   localparam int HALF = 8;

   logic        clk;
   logic        rst_n;
   logic        smpl_vld;
   logic [15:0] roll_rt, yaw_rt, AY, AZ;
   logic        INT, ovr;

   inert_sensor_serf_if spi_if ();

   inert_sensor_serf dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .spi      (spi_if),
      .smpl_vld (smpl_vld),
      .roll_rt  (roll_rt),
      .yaw_rt   (yaw_rt),
      .AY       (AY),
      .AZ       (AZ),
      .INT      (INT),
      .ovr      (ovr)
   );

   int n_cmp;
   int n_bad;

   logic [7:0]  m_rw [0:127];
   logic [15:0] m_roll, m_yaw, m_ay, m_az;
   logic        m_int, m_ovr;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Watchdog so the run always ends
   initial begin
      #3000000;
      $display("[TB] FAIL watchdog: simulation time limit reached, got running required finished");
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic void model_reset();
      for (int i = 0; i < 128; i++) m_rw[i] = 8'h00;
      m_roll = 16'h0; m_yaw = 16'h0; m_ay = 16'h0; m_az = 16'h0;
      m_int  = 1'b0;  m_ovr = 1'b0;
   endfunction

   function automatic logic model_is_rw(input logic [6:0] a);
      return (a == 7'h0D) || (a == 7'h10) || (a == 7'h11) || (a == 7'h14);
   endfunction

   function automatic logic [7:0] model_read(input logic [6:0] a);
      case (a)
         7'h0F:   return 8'h6A;
         7'h24:   return m_roll[7:0];
         7'h25:   return m_roll[15:8];
         7'h26:   return m_yaw[7:0];
         7'h27:   return m_yaw[15:8];
         7'h2A:   return m_ay[7:0];
         7'h2B:   return m_ay[15:8];
         7'h2C:   return m_az[7:0];
         7'h2D:   return m_az[15:8];
         default: return model_is_rw(a) ? m_rw[a] : 8'h00;
      endcase
   endfunction

   function automatic void model_sample(input logic [15:0] r, y, a, z);
      if (m_int) m_ovr = 1'b1;
      m_roll = r; m_yaw = y; m_ay = a; m_az = z;
      if (m_rw[13][1]) m_int = 1'b1;
   endfunction

   // One SPI frame, mode 3 style; optional sample strobe during bit pulse_at
   task automatic spi_xfer(input logic [15:0] tx, input int nbits, input int pulse_at,
                           output logic [15:0] rx);
      rx = 16'h0;
      @(negedge clk);
      spi_if.SS_n = 1'b0;
      repeat (HALF) @(negedge clk);
      for (int i = 0; i < nbits; i++) begin
         spi_if.SCLK = 1'b0;
         spi_if.MOSI = tx[15-i];
         if (i == pulse_at) begin
            smpl_vld = 1'b1;
            @(negedge clk);
            smpl_vld = 1'b0;
            repeat (HALF-1) @(negedge clk);
         end else begin
            repeat (HALF) @(negedge clk);
         end
         rx = {rx[14:0], spi_if.MISO};
         spi_if.SCLK = 1'b1;
         repeat (HALF) @(negedge clk);
      end
      spi_if.SS_n = 1'b1;
      spi_if.MOSI = 1'b0;
      repeat (HALF) @(negedge clk);
   endtask

   task automatic do_write(input logic [6:0] a, input logic [7:0] d);
      logic [15:0] rx;
      spi_xfer({1'b0, a, d}, 16, -1, rx);
      if (model_is_rw(a)) m_rw[a] = d;
   endtask

   task automatic do_read(input logic [6:0] a, output logic [15:0] rx);
      spi_xfer({1'b1, a, 8'h00}, 16, -1, rx);
      if (a == 7'h2D) m_int = 1'b0;
   endtask

   task automatic pulse_sample(input logic [15:0] r, y, a, z);
      @(negedge clk);
      roll_rt = r; yaw_rt = y; AY = a; AZ = z;
      smpl_vld = 1'b1;
      @(negedge clk);
      smpl_vld = 1'b0;
      model_sample(r, y, a, z);
      repeat (2) @(negedge clk);
   endtask

   task automatic test_reset();
      logic [15:0] rx, exp;
      rst_n = 1'b0;
      repeat (4) @(negedge clk);
      model_reset();
      n_cmp++;
      if ({INT, ovr, spi_if.MISO} !== 3'b000) begin
         n_bad++;
         $display("[TB] FAIL reset_outputs: INT/ovr/MISO got %b required 000", {INT, ovr, spi_if.MISO});
      end
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         logic [6:0] a;
         a = (i == 0) ? 7'h0D : (i == 1) ? 7'h10 : (i == 2) ? 7'h24 : 7'h2D;
         exp = {8'h00, model_read(a)};
         do_read(a, rx);
         n_cmp++;
         if (rx !== exp) begin
            n_bad++;
            $display("[TB] FAIL reset_read_%h: got %h required %h", a, rx, exp);
         end
      end
   endtask

   task automatic test_whoami();
      logic [15:0] rx;
      do_read(7'h0F, rx);
      n_cmp++;
      if (rx !== 16'h006A) begin
         n_bad++;
         $display("[TB] FAIL whoami: got %h required 006a", rx);
      end
   endtask

   task automatic test_rw_regs();
      logic [15:0] rx, exp;
      logic [6:0]  a;
      for (int i = 0; i < 7; i++) begin
         case (i)
            0: a = 7'h0D;  1: a = 7'h10;  2: a = 7'h11;  3: a = 7'h14;
            4: a = 7'h0F;  5: a = 7'h2D;  default: a = 7'h40 + 7'($urandom_range(0, 63));
         endcase
         do_write(a, 8'($urandom));
         exp = {8'h00, model_read(a)};
         do_read(a, rx);
         n_cmp++;
         if (rx !== exp) begin
            n_bad++;
            $display("[TB] FAIL rw_reg_%h: got %h required %h", a, rx, exp);
         end
      end
   endtask

   task automatic test_random_access();
      logic [15:0] rx, exp;
      logic [6:0]  a;
      for (int i = 0; i < 20; i++) begin
         a = 7'($urandom_range(0, 127));
         if ($urandom_range(0, 1) == 0) begin
            do_write(a, 8'($urandom));
         end else begin
            exp = {8'h00, model_read(a)};
            do_read(a, rx);
            n_cmp++;
            if (rx !== exp) begin
               n_bad++;
               $display("[TB] FAIL random_read_%h: got %h required %h", a, rx, exp);
            end
         end
      end
   endtask

   task automatic test_int_sample();
      logic [15:0] rx, exp;
      logic [6:0]  a;
      do_write(7'h0D, 8'h02);
      do_read(7'h0D, rx);
      n_cmp++;
      if (rx !== 16'h0002) begin
         n_bad++;
         $display("[TB] FAIL int_ctrl_read: got %h required 0002", rx);
      end
      pulse_sample(16'h1234, 16'($urandom), 16'($urandom), 16'hBEEF);
      n_cmp++;
      if (INT !== m_int) begin
         n_bad++;
         $display("[TB] FAIL int_set: INT got %b required %b", INT, m_int);
      end
      for (int i = 0; i < 8; i++) begin
         case (i)
            0: a = 7'h24;  1: a = 7'h25;  2: a = 7'h26;  3: a = 7'h27;
            4: a = 7'h2A;  5: a = 7'h2B;  6: a = 7'h2C;  default: a = 7'h2D;
         endcase
         exp = {8'h00, model_read(a)};
         do_read(a, rx);
         n_cmp++;
         if (rx !== exp || INT !== m_int) begin
            n_bad++;
            $display("[TB] FAIL int_data_read_%h: got %h INT %b required %h INT %b",
                     a, rx, INT, exp, m_int);
         end
      end
   endtask

   task automatic test_int_disabled();
      logic [15:0] rx, exp;
      do_write(7'h0D, 8'($urandom) & 8'hFD);
      pulse_sample(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
      repeat (4) @(negedge clk);
      n_cmp++;
      if (INT !== 1'b0) begin
         n_bad++;
         $display("[TB] FAIL int_disabled: INT got %b required 0", INT);
      end
      for (int i = 0; i < 4; i++) begin
         logic [6:0] a;
         a = (i == 0) ? 7'h24 : (i == 1) ? 7'h27 : (i == 2) ? 7'h2B : 7'h2C;
         exp = {8'h00, model_read(a)};
         do_read(a, rx);
         n_cmp++;
         if (rx !== exp) begin
            n_bad++;
            $display("[TB] FAIL int_disabled_read_%h: got %h required %h", a, rx, exp);
         end
      end
   endtask

   task automatic test_short_frame();
      logic [15:0] rx, exp;
      do_write(7'h10, 8'h00);
      spi_xfer(16'h1053, 10, -1, rx);
      exp = {8'h00, model_read(7'h10)};
      do_read(7'h10, rx);
      n_cmp++;
      if (rx !== exp) begin
         n_bad++;
         $display("[TB] FAIL short_write: got %h required %h", rx, exp);
      end
      do_write(7'h0D, 8'h02);
      pulse_sample(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
      spi_xfer(16'hAD00, 12, -1, rx);
      n_cmp++;
      if (INT !== 1'b1) begin
         n_bad++;
         $display("[TB] FAIL short_read_keeps_int: INT got %b required 1", INT);
      end
      do_read(7'h2D, rx);
      n_cmp++;
      if (INT !== 1'b0 || rx !== {8'h00, m_az[15:8]}) begin
         n_bad++;
         $display("[TB] FAIL full_read_clears_int: INT %b data %h required INT 0 data %h",
                  INT, rx, {8'h00, m_az[15:8]});
      end
   endtask

   task automatic test_pending();
      logic [15:0] rx, exp, nr, ny, na, nz;
      do_write(7'h0D, 8'h00);
      nr = 16'($urandom); ny = 16'($urandom); na = 16'($urandom); nz = 16'($urandom);
      roll_rt = ~nr; yaw_rt = ~ny; AY = ~na; AZ = ~nz;
      @(negedge clk);
      exp = {8'h00, model_read(7'h24)};
      fork
         begin
            spi_xfer(16'hA400, 16, 3, rx);
         end
         begin
            repeat (HALF * 14) @(negedge clk);
            roll_rt = nr; yaw_rt = ny; AY = na; AZ = nz;
            smpl_vld = 1'b1;
            @(negedge clk);
            smpl_vld = 1'b0;
         end
      join
      n_cmp++;
      if (rx !== exp) begin
         n_bad++;
         $display("[TB] FAIL pending_old_value: got %h required %h", rx, exp);
      end
      model_sample(nr, ny, na, nz);
      exp = {8'h00, model_read(7'h24)};
      do_read(7'h24, rx);
      n_cmp++;
      if (rx !== exp) begin
         n_bad++;
         $display("[TB] FAIL pending_new_value: got %h required %h", rx, exp);
      end
      exp = {8'h00, model_read(7'h2D)};
      do_read(7'h2D, rx);
      n_cmp++;
      if (rx !== exp || INT !== 1'b0) begin
         n_bad++;
         $display("[TB] FAIL pending_latest_az: got %h INT %b required %h INT 0", rx, INT, exp);
      end
   endtask

   task automatic test_ovr_and_async_reset();
      logic [15:0] rx, exp;
      do_write(7'h0D, 8'h02);
      pulse_sample(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
      n_cmp++;
      if (ovr !== m_ovr || INT !== m_int) begin
         n_bad++;
         $display("[TB] FAIL ovr_first_sample: ovr %b INT %b required ovr %b INT %b",
                  ovr, INT, m_ovr, m_int);
      end
      pulse_sample(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
      n_cmp++;
      if (ovr !== m_ovr) begin
         n_bad++;
         $display("[TB] FAIL ovr_second_sample: ovr got %b required %b", ovr, m_ovr);
      end
      do_read(7'h2D, rx);
      n_cmp++;
      if (ovr !== m_ovr || INT !== m_int) begin
         n_bad++;
         $display("[TB] FAIL ovr_sticky: ovr %b INT %b required ovr %b INT %b",
                  ovr, INT, m_ovr, m_int);
      end
      pulse_sample(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
      spi_if.SS_n = 1'b0;
      repeat (HALF) @(negedge clk);
      for (int i = 0; i < 5; i++) begin
         spi_if.SCLK = 1'b0; spi_if.MOSI = 1'b1;
         repeat (HALF) @(negedge clk);
         spi_if.SCLK = 1'b1;
         repeat (HALF) @(negedge clk);
      end
      rst_n = 1'b0;
      model_reset();
      @(negedge clk);
      n_cmp++;
      if ({INT, ovr, spi_if.MISO} !== 3'b000) begin
         n_bad++;
         $display("[TB] FAIL midframe_reset: INT/ovr/MISO got %b required 000", {INT, ovr, spi_if.MISO});
      end
      spi_if.SS_n = 1'b1; spi_if.MOSI = 1'b0;
      repeat (4) @(negedge clk);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
      exp = {8'h00, model_read(7'h0D)};
      do_read(7'h0D, rx);
      n_cmp++;
      if (rx !== exp) begin
         n_bad++;
         $display("[TB] FAIL post_reset_int_ctrl: got %h required %h", rx, exp);
      end
      exp = {8'h00, model_read(7'h2C)};
      do_read(7'h2C, rx);
      n_cmp++;
      if (rx !== exp) begin
         n_bad++;
         $display("[TB] FAIL post_reset_az_l: got %h required %h", rx, exp);
      end
   endtask

   initial begin
      n_cmp = 0;
      n_bad = 0;
      rst_n = 1'b0;
      smpl_vld = 1'b0;
      roll_rt = 16'h0; yaw_rt = 16'h0; AY = 16'h0; AZ = 16'h0;
      spi_if.SS_n = 1'b1;
      spi_if.SCLK = 1'b1;
      spi_if.MOSI = 1'b0;
      model_reset();
      test_reset();
      test_whoami();
      test_rw_regs();
      test_random_access();
      test_int_sample();
      test_int_disabled();
      test_short_frame();
      test_pending();
      test_ovr_and_async_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
